pu_ctl: RTL and testbench
=========================

# pu_ctl

Run/debug controller for the processing unit. It sequences execution by gating PC advance and register-array writeback. It supports free-run, single-step, host stop, halt-instruction and PC-breakpoint stops, and counts retired instructions. It sits beside `pu`: it consumes `pca` and the decoder halt flag `h`, and drives the enables that `pc` and `ra` honour.

## Interface
- `PCW`, default 8: PC width; must equal `` `PCS``+1.
- `CNTW`, default 16: retired-instruction counter width.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request, level sampled per cycle.
- `step`  in  1  single-step request.
- `stop`  in  1  host stop request.
- `clr`  in  1  return to IDLE, restart program.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  PCW  breakpoint PC.
- `h`  in  1  current instruction is halt (from `dec`).
- `pca`  in  PCW  current PC (from `pc`).
- `pce`  out  1  PC advance enable; `pc` holds when 0.
- `wen`  out  1  writeback gate; ANDed with `dec` `we` at `ra`.
- `pc_clr`  out  1  one-cycle synchronous PC reload to 0.
- `busy`  out  1  state is RUN or STEP.
- `halted`  out  1  state is HALT.
- `cause`  out  2  last stop reason: 0 none/step done, 1 halt instr, 2 breakpoint, 3 host stop.
- `icnt`  out  CNTW  retired instructions, saturating.

## Operation
- States: IDLE (reset), RUN, STEP, HALT.
- `pce`, `wen`, and `pc_clr` are combinational from state and inputs. All other outputs are registered.
- A retire occurs in a cycle with `pce`=1. On a retire, `icnt` increments and holds at all-ones.
- IDLE/HALT transitions:
  - `start`: go to RUN.
  - `step` with `start`=0: go to STEP.
  - `start` and `step` together: `start` wins.
  - No retire occurs in IDLE or HALT.
- RUN, evaluated each cycle in priority order:
  1. `h`=1: no retire, go to HALT, `cause`=1.
  2. Breakpoint hit (`bp_en` and `pca`==`bp_addr`, not first cycle after entry): no retire, go to HALT, `cause`=2.
  3. `stop`: no retire, go to HALT, `cause`=3.
  4. Otherwise: retire, stay in RUN.
- First-cycle rule: a registered `first` flag is set on entry to RUN or STEP. While it is set, the breakpoint check is masked, so resuming from a breakpoint executes that instruction.
- STEP:
  - `h`=1: no retire, go to HALT, `cause`=1.
  - Otherwise: retire exactly one instruction, go to HALT, `cause`=0.
  - The breakpoint check is ignored. `stop` is ignored.
- `start`/`step` are ignored in RUN and STEP.
- `clr` in any state:
  - `pc_clr`=1 and `pce`=`wen`=0 in that cycle.
  - Next state is IDLE, with `icnt`=0 and `cause`=0.
  - `clr` overrides all other inputs.
- Halt persistence: the PC does not advance past a halt instruction. A `start` from HALT with `h` still 1 therefore re-halts next cycle with `cause`=1 and no retire.
- Reset mid-operation: all state clears immediately and asynchronously. `pce`/`wen` drop without waiting for a clock.

## Timing
- Reset values:
  - state IDLE
  - `pce`, `wen`, `pc_clr`, `busy`, `halted`: 0
  - `cause`: 0
  - `icnt`: 0
  - `first`: 0
- Request latency: `start`/`step` sampled at edge N gives state RUN/STEP from N. The first retire is in cycle N..N+1, with `pce`=1 combinationally.
- Stop latency: a stop condition in cycle K suppresses the retire in cycle K. `halted`=1 from edge K+1.
- `icnt` updates on the edge closing a retire cycle.
- `cause` updates on the HALT-entry edge and holds until the next HALT entry or `clr`.
- No combinational path runs from `pce`/`wen` back into `h` or `pca` inside this block.

## Structure
- Package `pu_ctl_pkg`:
  - `state_t` enum {IDLE, RUN, STEP, HALT}.
  - `cause_t` enum {C_NONE, C_HALT, C_BP, C_STOP}.
- Sub-module `sat_cnt` (params `W`): async active-low reset, inputs `clr`/`inc`, saturating. Used for `icnt`.
- `pu` integration:
  - `pc` gains a `pce`/`pc_clr` input.
  - `ra` write enable becomes `we & wen`.

## Test plan
- Reset, then `start` with `h`=0 for 10 cycles, then `stop` → `icnt`=10, `halted`=1, `cause`=3, `pce`=0 in the stop cycle.
- Program halts at PC 5 (`h`=1 when `pca`=5) → `icnt`=5, `cause`=1. A second `start` gives `icnt`=5, `cause`=1 with no retire.
- `bp_en`=1, `bp_addr`=3, `start` → halt with `pca`=3, `icnt`=3, `cause`=2. A second `start` retires PC 3 and runs on.
- From HALT, three `step` pulses, one cycle apart from HALT → `icnt` +3, `cause`=0 each time, with exactly one `pce` pulse per step.
- `clr` during RUN with `start`=1 → `pc_clr`=1 for one cycle, then IDLE, `icnt`=0. `start`+`step` together → RUN.
- `CNTW`=4: run 20 instructions → `icnt`=15. Assert `rst` low mid-RUN → `pce`=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/pu_ctl_pkg.sv
// Shared types for the processing-unit run/debug controller.
package pu_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_HALT,
    C_BP,
    C_STOP
  } cause_t;

endpackage

// File: rtl/pu_ctl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pu_ctl.sv
// Run/debug controller: gates PC advance and writeback, handles step,
// host stop, halt instruction and PC breakpoint, counts retired instructions.
module pu_ctl
  import pu_ctl_pkg::*;
#(
  parameter int PCW  = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            stop,
  input  logic            clr,
  input  logic            bp_en,
  input  logic [PCW-1:0]  bp_addr,
  input  logic            h,
  input  logic [PCW-1:0]  pca,
  output logic            pce,
  output logic            wen,
  output logic            pc_clr,
  output logic            busy,
  output logic            halted,
  output logic [1:0]      cause,
  output logic [CNTW-1:0] icnt
);

  state_t state;
  cause_t cause_q;
  logic   first;
  logic   bp_hit;
  logic   retire;

  // The breakpoint is masked on the first cycle after entry so that
  // resuming from a breakpoint executes the instruction it stopped on.
  always_comb begin
    bp_hit = bp_en && (pca == bp_addr) && !first;
    retire = 1'b0;
    case (state)
      RUN:     retire = !h && !bp_hit && !stop;
      STEP:    retire = !h;
      default: retire = 1'b0;
    endcase
    if (clr) begin
      retire = 1'b0;
    end
  end

  assign pce    = retire;
  assign wen    = retire;
  assign pc_clr = clr && rst;
  assign cause  = cause_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      first   <= 1'b0;
      cause_q <= C_NONE;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      first   <= 1'b0;
      cause_q <= C_NONE;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state  <= RUN;
            first  <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end else if (step) begin
            state  <= STEP;
            first  <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        RUN: begin
          first <= 1'b0;
          if (h || bp_hit || stop) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            if (h) begin
              cause_q <= C_HALT;
            end else if (bp_hit) begin
              cause_q <= C_BP;
            end else begin
              cause_q <= C_STOP;
            end
          end
        end
        STEP: begin
          first   <= 1'b0;
          state   <= HALT;
          busy    <= 1'b0;
          halted  <= 1'b1;
          cause_q <= h ? C_HALT : C_NONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt #(.W(CNTW)) u_icnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (retire),
    .q   (icnt)
  );

endmodule

// File: tb/tb_pu_ctl.sv
// Self-checking bench for pu_ctl: vector table, directed corner sequences,
// and randomized stimulus against a behavioural run/stop model.
module tb_pu_ctl;

  localparam int PCW  = 8;
  localparam int CNTW = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, step, stop, clr, bp_en, h_force, halt_en, h;
  logic [PCW-1:0] bp_addr, pca, halt_pc;
  logic           pce, wen, pc_clr, busy, halted;
  logic [1:0]     cause;
  logic [CNTW-1:0] icnt;
  logic           pce4, wen4, pc_clr4, busy4, halted4;
  logic [1:0]     cause4;
  logic [3:0]     icnt4;

  // The program's halt instruction sits at halt_pc when enabled.
  assign h = h_force | (halt_en && (pca == halt_pc));

  pu_ctl #(.PCW(PCW), .CNTW(CNTW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop), .clr(clr),
    .bp_en(bp_en), .bp_addr(bp_addr), .h(h), .pca(pca),
    .pce(pce), .wen(wen), .pc_clr(pc_clr), .busy(busy), .halted(halted),
    .cause(cause), .icnt(icnt)
  );

  pu_ctl #(.PCW(PCW), .CNTW(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop), .clr(clr),
    .bp_en(bp_en), .bp_addr(bp_addr), .h(h), .pca(pca),
    .pce(pce4), .wen(wen4), .pc_clr(pc_clr4), .busy(busy4), .halted(halted4),
    .cause(cause4), .icnt(icnt4)
  );

  int total = 0;
  int bad   = 0;
  int m_mode, m_cause, m_cnt, m_cnt4;
  bit m_fresh;
  logic obs_pce, obs_pcc;
  int n_pulse;

  typedef struct {
    bit clr, start, step, stop, bp_en;
    logic [7:0] bp_addr;
    bit hf;
    bit e_pce, e_pcc, e_busy, e_halted;
    int e_cause, e_icnt;
  } vec_t;

  vec_t tbl [17];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_mode = M_IDLE; m_fresh = 0; m_cause = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic applyStimulus(input bit c, input bit s, input bit st, input bit sp,
                               input bit be, input logic [7:0] ba, input bit hf);
    clr = c; start = s; step = st; stop = sp; bp_en = be; bp_addr = ba; h_force = hf;
  endtask

  // One clock: check the enables mid-cycle, advance model and PC, check registers.
  task automatic runCycle();
    bit ret, pcc;
    #1;
    pcc = clr;
    ret = 0;
    if (!clr) begin
      if (m_mode == M_RUN)
        ret = !h && !(bp_en && (pca == bp_addr) && !m_fresh) && !stop;
      else if (m_mode == M_STEP)
        ret = !h;
    end
    obs_pce = pce;
    obs_pcc = pc_clr;
    if (pce === 1'b1) n_pulse++;
    checkOutput("pce", pce, ret);
    checkOutput("wen", wen, ret);
    checkOutput("pc_clr", pc_clr, pcc);
    checkOutput("pce4", pce4, ret);
    @(posedge clk);
    #1;
    if (clr) begin
      m_mode = M_IDLE; m_fresh = 0; m_cause = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (m_mode == M_IDLE || m_mode == M_HALT) begin
      if (start)     begin m_mode = M_RUN;  m_fresh = 1; end
      else if (step) begin m_mode = M_STEP; m_fresh = 1; end
    end else if (m_mode == M_RUN) begin
      if (h)                                              begin m_mode = M_HALT; m_cause = 1; end
      else if (bp_en && (pca == bp_addr) && !m_fresh)     begin m_mode = M_HALT; m_cause = 2; end
      else if (stop)                                      begin m_mode = M_HALT; m_cause = 3; end
      m_fresh = 0;
    end else begin
      m_cause = h ? 1 : 0;
      m_mode  = M_HALT;
      m_fresh = 0;
    end
    if (ret) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (pcc) pca = '0;
    else if (ret) pca = pca + 8'd1;
    checkOutput("busy", busy, (m_mode == M_RUN || m_mode == M_STEP));
    checkOutput("halted", halted, (m_mode == M_HALT));
    checkOutput("cause", cause, m_cause);
    checkOutput("icnt", icnt, m_cnt);
    checkOutput("icnt4", icnt4, m_cnt4);
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 0);
    halt_en = 0; halt_pc = '0; pca = '0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic waitHalted(input string name);
    int budget;
    budget = 60;
    while (halted !== 1'b1 && budget > 0) begin
      runCycle();
      budget--;
    end
    if (budget == 0) checkOutput(name, 0, 1);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 0);
    halt_en = 0; halt_pc = '0; pca = '0;
    #3;
    checkOutput("rst_pce", pce, 0);
    checkOutput("rst_wen", wen, 0);
    checkOutput("rst_pc_clr", pc_clr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_cause", cause, 0);
    checkOutput("rst_icnt", icnt, 0);

    // clr start step stop bp_en bp_addr h | pce pcc busy halted cause icnt
    tbl[0]  = '{0,1,0,0,0,8'd0,0, 0,0,1,0,0,0};
    tbl[1]  = '{0,0,0,0,0,8'd0,0, 1,0,1,0,0,1};
    tbl[2]  = '{0,0,0,0,0,8'd0,0, 1,0,1,0,0,2};
    tbl[3]  = '{0,0,0,1,0,8'd0,0, 0,0,0,1,3,2};
    tbl[4]  = '{0,0,1,0,0,8'd0,0, 0,0,1,0,3,2};
    tbl[5]  = '{0,0,0,0,0,8'd0,0, 1,0,0,1,0,3};
    tbl[6]  = '{0,1,1,0,0,8'd0,0, 0,0,1,0,0,3};
    tbl[7]  = '{0,0,0,0,0,8'd0,1, 0,0,0,1,1,3};
    tbl[8]  = '{0,1,0,0,0,8'd0,1, 0,0,1,0,1,3};
    tbl[9]  = '{0,0,0,0,0,8'd0,1, 0,0,0,1,1,3};
    tbl[10] = '{0,1,0,0,0,8'd0,0, 0,0,1,0,1,3};
    tbl[11] = '{0,0,0,0,1,8'd3,0, 1,0,1,0,1,4};
    tbl[12] = '{0,0,0,0,1,8'd5,0, 1,0,1,0,1,5};
    tbl[13] = '{0,0,0,0,1,8'd5,0, 0,0,0,1,2,5};
    tbl[14] = '{1,1,0,0,0,8'd0,0, 0,1,0,0,0,0};
    tbl[15] = '{0,0,1,0,0,8'd0,0, 0,0,1,0,0,0};
    tbl[16] = '{0,0,0,1,1,8'd0,0, 1,0,0,1,0,1};

    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].clr, tbl[i].start, tbl[i].step, tbl[i].stop,
                    tbl[i].bp_en, tbl[i].bp_addr, tbl[i].hf);
      runCycle();
      checkOutput($sformatf("vec%0d_pce", i), obs_pce, tbl[i].e_pce);
      checkOutput($sformatf("vec%0d_pc_clr", i), obs_pcc, tbl[i].e_pcc);
      checkOutput($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      checkOutput($sformatf("vec%0d_halted", i), halted, tbl[i].e_halted);
      checkOutput($sformatf("vec%0d_cause", i), cause, tbl[i].e_cause);
      checkOutput($sformatf("vec%0d_icnt", i), icnt, tbl[i].e_icnt);
    end

    // Free run for 10 instructions, then host stop.
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 0);
    repeat (10) runCycle();
    applyStimulus(0, 0, 0, 1, 0, 8'd0, 0); runCycle();
    checkOutput("stop_pce", obs_pce, 0);
    checkOutput("stop_icnt", icnt, 10);
    checkOutput("stop_halted", halted, 1);
    checkOutput("stop_cause", cause, 3);

    // Halt instruction at PC 5, then a restart that must re-halt.
    applyStimulus(1, 0, 0, 0, 0, 8'd0, 0); runCycle();
    halt_en = 1; halt_pc = 8'd5;
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 0);
    waitHalted("halt_timeout");
    checkOutput("halt_icnt", icnt, 5);
    checkOutput("halt_cause", cause, 1);
    checkOutput("halt_pca", pca, 5);
    n_pulse = 0;
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 0); runCycle();
    checkOutput("rehalt_pulses", n_pulse, 0);
    checkOutput("rehalt_icnt", icnt, 5);
    checkOutput("rehalt_cause", cause, 1);
    checkOutput("rehalt_halted", halted, 1);

    // Breakpoint at PC 3, then resume through it.
    halt_en = 0;
    applyStimulus(1, 0, 0, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 1, 0, 0, 1, 8'd3, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 1, 8'd3, 0);
    waitHalted("bp_timeout");
    checkOutput("bp_pca", pca, 3);
    checkOutput("bp_icnt", icnt, 3);
    checkOutput("bp_cause", cause, 2);
    applyStimulus(0, 1, 0, 0, 1, 8'd3, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 1, 8'd3, 0); runCycle();
    checkOutput("bp_resume_pce", obs_pce, 1);
    runCycle();
    checkOutput("bp_resume_icnt", icnt, 5);
    checkOutput("bp_resume_busy", busy, 1);
    applyStimulus(0, 0, 0, 1, 1, 8'd3, 0); runCycle();
    checkOutput("bp_stop_halted", halted, 1);

    // Three single steps from HALT.
    n_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0, 1, 8'd3, 0); runCycle();
      applyStimulus(0, 0, 0, 0, 1, 8'd3, 0); runCycle();
      checkOutput($sformatf("step%0d_cause", k), cause, 0);
      checkOutput($sformatf("step%0d_halted", k), halted, 1);
    end
    checkOutput("step_pulses", n_pulse, 3);
    checkOutput("step_icnt", icnt, 8);

    // clr while running with start held, then start+step priority.
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 0); runCycle(); runCycle();
    applyStimulus(1, 1, 0, 0, 0, 8'd0, 0); runCycle();
    checkOutput("clr_pc_clr", obs_pcc, 1);
    checkOutput("clr_pce", obs_pce, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_icnt", icnt, 0);
    checkOutput("clr_pca", pca, 0);
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 0); runCycle();
    checkOutput("post_clr_pc_clr", obs_pcc, 0);
    checkOutput("post_clr_busy", busy, 1);
    applyStimulus(1, 0, 0, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 1, 1, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 0); runCycle(); runCycle();
    checkOutput("both_busy", busy, 1);
    checkOutput("both_icnt", icnt, 2);

    // Saturation in the 4-bit counter, then asynchronous reset mid-run.
    applyStimulus(1, 0, 0, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 1, 0, 0, 0, 8'd0, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 0, 8'd0, 0);
    repeat (20) runCycle();
    checkOutput("sat_icnt4", icnt4, 15);
    checkOutput("sat_icnt", icnt, 20);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_pce", pce, 0);
    checkOutput("arst_wen", wen, 0);
    checkOutput("arst_pce4", pce4, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_halted", halted, 0);
    checkOutput("arst_cause", cause, 0);
    checkOutput("arst_icnt", icnt, 0);
    checkOutput("arst_icnt4", icnt4, 0);
    doReset();

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 15)),
                    ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 15) == 0) begin
        halt_en = ($urandom_range(0, 1) == 1);
        halt_pc = 8'($urandom_range(0, 20));
      end
      runCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] time limit");
  end

endmodule
